// File: rtl/vector_serializer.sv
// Captures a packed vector on start and streams its elements out one per
// accepted handshake, lowest index first, with synchronous abort.
module vector_serializer #(
    parameter int  ELEMENT_COUNT = 256,
    parameter int  DATA_WIDTH    = 16,
    localparam int IDX_WIDTH     = (ELEMENT_COUNT > 1) ? $clog2(ELEMENT_COUNT) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [DATA_WIDTH*ELEMENT_COUNT-1:0] vector_in,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [IDX_WIDTH-1:0]                out_index,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                done
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ELEMENT_COUNT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  load;
    logic                  advance;
    logic                  finish;
    logic [IDX_WIDTH-1:0]  idx_next;
    logic [DATA_WIDTH-1:0] buf_q [ELEMENT_COUNT];

    // Handshake: an element moves when out_valid && out_ready at a rising edge
    // and abort is low; out_data/out_index/out_last hold until that happens.
    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_last  = out_valid && (out_index == LAST_IDX);
    assign idx_next  = out_index + IDX_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    load    = 1'b1;
                end
            end
            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (out_index == LAST_IDX) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            out_data  <= '0;
            out_index <= '0;
            done      <= 1'b0;
            for (int i = 0; i < ELEMENT_COUNT; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done    <= finish;
            if (load) begin
                // Element 0 goes straight to the output so it is offered one
                // cycle after start; the buffer feeds every later element.
                for (int i = 0; i < ELEMENT_COUNT; i++) begin
                    buf_q[i] <= vector_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
                out_data  <= vector_in[DATA_WIDTH-1:0];
                out_index <= '0;
            end else if (advance) begin
                out_data  <= buf_q[idx_next];
                out_index <= idx_next;
            end
        end
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Directed bench for vector_serializer (4 x 16-bit): driver pushes expected
// elements and done pulses into queues; a negedge monitor pops and compares.
module tb_vector_serializer;

    localparam int EC = 4;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int XW = DW + IW + 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [DW*EC-1:0] vector_in;
    logic [DW-1:0]    out_data;
    logic [IW-1:0]    out_index;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    logic [XW-1:0] exp_q[$];
    logic          done_q[$];
    int            checks;
    int            passes;

    localparam logic [DW*EC-1:0] VEC_A = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    localparam logic [DW*EC-1:0] VEC_B = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    localparam logic [DW*EC-1:0] VEC_X = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};

    vector_serializer #(.ELEMENT_COUNT(EC), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .vector_in (vector_in),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [DW*EC-1:0] v, input int n, input logic with_done);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({v[i*DW +: DW], IW'(i), (i == EC - 1)});
        end
        if (with_done) done_q.push_back(1'b1);
    endtask

    task automatic issue_start(input logic [DW*EC-1:0] v);
        vector_in = v;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (!done && cycles < 50) begin
            cycle();
            cycles++;
        end
        if (!done) begin
            checks++;
            $display("FAIL %s_done_wait actual=no_done required=done_within_50", name);
        end
    endtask

    // scoreboard monitor: a transfer is valid && ready without abort
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_transfer actual=0x%0h required=none", out_data);
            end else begin
                logic [XW-1:0] e;
                e = exp_q.pop_front();
                check("xfer", {13'd0, out_data, out_index, out_last}, {13'd0, e});
            end
        end
        if (!rst && done) begin
            if (done_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                void'(done_q.pop_front());
                check("done_busy_low", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        int n;
        checks    = 0;
        passes    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        vector_in = '0;
        #3;
        check("reset_outputs", {done, busy, out_valid, out_last, out_index, out_data}, 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("idle_after_reset", {30'd0, out_valid, busy}, 32'd0);

        // plain stream, no backpressure
        out_ready = 1'b1;
        push_stream(VEC_A, EC, 1'b1);
        issue_start(VEC_A);
        check("first_elem", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h0011});
        check("first_idx", {30'd0, out_index}, 32'd0);
        wait_done("plain", n);
        check("plain_latency", n, 32'd4);
        check("plain_done_state", {29'd0, done, busy, out_valid}, 32'b100);
        cycle();
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // backpressure at index 1
        push_stream(VEC_A, EC, 1'b1);
        issue_start(VEC_A);
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_data", {16'd0, out_data}, 32'h0022);
            check("hold_idx", {30'd0, out_index}, 32'd1);
        end
        out_ready = 1'b1;
        wait_done("bp", n);
        check("bp_latency", n, 32'd3);
        cycle();

        // start during stream with a different vector is ignored
        push_stream(VEC_A, EC, 1'b1);
        issue_start(VEC_A);
        cycle();
        cycle();
        check("ign_idx2", {30'd0, out_index}, 32'd2);
        issue_start(VEC_X);
        check("ign_data3", {16'd0, out_data}, 32'h0044);
        wait_done("ign", n);
        cycle();
        check("ign_no_restart", {30'd0, out_valid, busy}, 32'd0);

        // abort coincident with the final transfer
        push_stream(VEC_A, EC - 1, 1'b0);
        issue_start(VEC_A);
        cycle();
        cycle();
        cycle();
        check("abort_at_last", {30'd0, out_index}, 32'd3);
        check("abort_last_flag", {31'd0, out_last}, 32'd1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_state", {29'd0, done, busy, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) cycle();

        // back-to-back: start during the done cycle
        push_stream(VEC_A, EC, 1'b1);
        issue_start(VEC_A);
        wait_done("b2b_a", n);
        push_stream(VEC_B, EC, 1'b1);
        issue_start(VEC_B);
        check("b2b_first", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h000A});
        check("b2b_idx", {30'd0, out_index}, 32'd0);
        wait_done("b2b_b", n);
        check("b2b_latency", n, 32'd4);
        cycle();

        // asynchronous reset mid-stream
        push_stream(VEC_A, 2, 1'b0);
        issue_start(VEC_A);
        cycle();
        cycle();
        check("rst_idx2", {30'd0, out_index}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {done, busy, out_valid, out_last, out_index, out_data}, 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        push_stream(VEC_B, EC, 1'b1);
        issue_start(VEC_B);
        check("rst_restart", {14'd0, out_index, out_data}, {14'd0, 2'd0, 16'h000A});
        wait_done("rst", n);
        for (int i = 0; i < 3; i++) cycle();

        check("exp_q_drained", exp_q.size(), 32'd0);
        check("done_q_drained", done_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
